// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
// Frame width, default baud divisor and receiver FSM states.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int CLK_PER_BIT_DEF = 87;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO with count-based full/empty.
// Head word is forced to zero while empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 3-sample majority vote feeding a byte FIFO.
// Framing errors and FIFO overflows are reported as single-cycle pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int FIFO_DEPTH  = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overflow,
  output logic [CW-1:0]        o_count
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int BI_W  = $clog2(DATA_BITS);
  localparam int M     = CLK_PER_BIT / 2;

  localparam logic [CNT_W-1:0] C_LO  = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] C_MID = CNT_W'(M);
  localparam logic [CNT_W-1:0] C_HI  = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(CLK_PER_BIT - 1);

  uart_state_e          state, state_n;
  logic [CNT_W-1:0]     clk_cnt, cnt_n;
  logic [BI_W-1:0]      bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic [DATA_BITS-1:0] push_data;
  logic                 rx_meta, rx_s, rx_prev;
  logic                 smp_a, smp_b, a_n, b_n;
  logic                 push_req, push_n;
  logic                 ferr_n;
  logic                 vote, at_hi, at_end;
  logic                 full, empty, pop;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign vote   = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign at_hi  = (clk_cnt == C_HI);
  assign at_end = (clk_cnt == C_END);

  always_comb begin
    state_n = state;
    cnt_n   = at_end ? '0 : clk_cnt + 1'b1;
    bit_n   = bit_idx;
    sh_n    = shreg;
    push_n  = 1'b0;
    ferr_n  = 1'b0;
    a_n     = (clk_cnt == C_LO)  ? rx_s : smp_a;
    b_n     = (clk_cnt == C_MID) ? rx_s : smp_b;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_prev & ~rx_s) state_n = START;
      end
      START: begin
        if (at_hi && vote) begin
          state_n = IDLE;
        end else if (at_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (at_hi) sh_n = {vote, shreg[DATA_BITS-1:1]};
        if (at_end) begin
          bit_n = bit_idx + 1'b1;
          if (bit_idx == BI_W'(DATA_BITS - 1)) state_n = STOP;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so the next start edge is never missed.
        if (at_hi) begin
          if (vote) begin
            push_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      smp_a       <= 1'b0;
      smp_b       <= 1'b0;
      push_req    <= 1'b0;
      push_data   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= cnt_n;
      bit_idx     <= bit_n;
      shreg       <= sh_n;
      smp_a       <= a_n;
      smp_b       <= b_n;
      push_req    <= push_n;
      o_frame_err <= ferr_n;
      if (push_n) push_data <= shreg;
    end
  end

  assign o_valid    = ~empty;
  assign pop        = o_valid & i_ready;
  assign o_overflow = push_req & full & ~pop;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .push  (push_req),
    .wdata (push_data),
    .pop   (pop),
    .rdata (o_data),
    .full  (full),
    .empty (empty),
    .count (o_count)
  );

endmodule
